// File: rtl/mux_sched_pkg.sv
// Shared types and helpers for the LED row multiplexing scheduler.
// No logic; state encoding and row decode only.
package mux_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_WAIT,
      ST_BLANK,
      ST_LATCH
   } mux_sched_state_t;

   localparam int NB_MUX_ROWS_DEFAULT = 4;
   localparam int MAX_MUX_ROWS        = 32;

   function automatic logic [MAX_MUX_ROWS-1:0] row_onehot(input int unsigned idx);
      return 32'd1 << idx;
   endfunction

endpackage

// File: rtl/mux_row_scheduler_if.sv
// Scheduler <-> driver/lookup bus: led fetch handshake, driver completion and row outputs.
// Master is the scheduler; slave is the frame-buffer read path and LED driver side.
interface mux_row_scheduler_if
   import mux_sched_pkg::*;
#(
   parameter int NB_LEDS_PER_GROUP = 16,
   parameter int NB_MUX_ROWS       = NB_MUX_ROWS_DEFAULT
);
   localparam int LED_W = $clog2(NB_LEDS_PER_GROUP);

   logic [LED_W-1:0]       led;
   logic                   led_valid;
   logic                   led_ready;
   logic                   drv_done;
   logic                   latch;
   logic                   blank;
   logic [NB_MUX_ROWS-1:0] mux_en;
   logic                   frame_start;

   modport master (
      output led, led_valid, latch, blank, mux_en, frame_start,
      input  led_ready, drv_done
   );

   modport slave (
      input  led, led_valid, latch, blank, mux_en, frame_start,
      output led_ready, drv_done
   );
endinterface

// File: rtl/mux_row_timer.sv
// Saturating up-counter; load restarts it at 1 so the load cycle itself is counted.
// expired is high once LIMIT cycles have elapsed since the load; no backpressure.
module mux_row_timer #(
   parameter int LIMIT = 4096,
   parameter int W     = $clog2(LIMIT + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   output logic expired
);
   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= W'(1);
      end else if (cnt < W'(LIMIT)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign expired = (cnt >= W'(LIMIT));
endmodule

// File: rtl/mux_row_scheduler.sv
// LED row multiplexing sequencer: fetch indices, hold row time, blank, latch, advance row.
// All outputs registered (1-cycle response); led held while led_valid && !led_ready.
module mux_row_scheduler
   import mux_sched_pkg::*;
#(
   parameter int NB_LEDS_PER_GROUP = 16,
   parameter int NB_MUX_ROWS       = NB_MUX_ROWS_DEFAULT,
   parameter int ROW_CYCLES        = 4096,
   parameter int BLANK_CYCLES      = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   output logic                busy,
   mux_row_scheduler_if.master bus
);
   localparam int LED_W = $clog2(NB_LEDS_PER_GROUP);
   localparam int RW    = (NB_MUX_ROWS > 1) ? $clog2(NB_MUX_ROWS) : 1;

   mux_sched_state_t state;
   logic [RW-1:0]    row;
   logic [RW-1:0]    next_row;
   logic             row_valid;
   logic             done_seen;
   logic             row_expired;
   logic             blank_expired;
   logic             wait_exit;

   // A row that has not been switched on yet imposes no minimum display time.
   assign wait_exit = (done_seen || bus.drv_done) && (row_expired || !row_valid);

   always_comb begin
      next_row = '0;
      if (row_valid) begin
         next_row = (row == RW'(NB_MUX_ROWS - 1)) ? '0 : row + 1'b1;
      end
   end

   mux_row_timer #(.LIMIT(ROW_CYCLES)) u_row_timer (
      .clk     (clk),
      .rst     (rst),
      .load    (state == ST_LATCH),
      .expired (row_expired)
   );

   mux_row_timer #(.LIMIT(BLANK_CYCLES)) u_blank_timer (
      .clk     (clk),
      .rst     (rst),
      .load    ((state == ST_WAIT) && wait_exit),
      .expired (blank_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= ST_IDLE;
         row             <= '0;
         row_valid       <= 1'b0;
         done_seen       <= 1'b0;
         busy            <= 1'b0;
         bus.led         <= '0;
         bus.led_valid   <= 1'b0;
         bus.latch       <= 1'b0;
         bus.blank       <= 1'b1;
         bus.mux_en      <= '0;
         bus.frame_start <= 1'b0;
      end else begin
         bus.latch       <= 1'b0;
         bus.frame_start <= 1'b0;
         if ((state == ST_SHIFT || state == ST_WAIT) && bus.drv_done) begin
            done_seen <= 1'b1;
         end
         case (state)
            ST_IDLE: begin
               // A row left on by the disable path must serve its full time before going dark.
               if (row_valid) begin
                  if (row_expired) begin
                     row_valid  <= 1'b0;
                     bus.mux_en <= '0;
                     bus.blank  <= 1'b1;
                  end
               end else if (enable) begin
                  state         <= ST_SHIFT;
                  bus.led       <= '0;
                  bus.led_valid <= 1'b1;
                  busy          <= 1'b1;
               end
            end
            ST_SHIFT: begin
               if (bus.led_ready) begin
                  if (bus.led == LED_W'(NB_LEDS_PER_GROUP - 1)) begin
                     bus.led       <= '0;
                     bus.led_valid <= 1'b0;
                     state         <= ST_WAIT;
                  end else begin
                     bus.led <= bus.led + 1'b1;
                  end
               end
            end
            ST_WAIT: begin
               if (wait_exit) begin
                  state      <= ST_BLANK;
                  bus.mux_en <= '0;
                  bus.blank  <= 1'b1;
               end
            end
            ST_BLANK: begin
               if (blank_expired) begin
                  state     <= ST_LATCH;
                  bus.latch <= 1'b1;
               end
            end
            ST_LATCH: begin
               row             <= next_row;
               row_valid       <= 1'b1;
               bus.mux_en      <= NB_MUX_ROWS'(row_onehot(32'(next_row)));
               bus.blank       <= 1'b0;
               bus.frame_start <= (next_row == '0);
               done_seen       <= 1'b0;
               if (enable) begin
                  state         <= ST_SHIFT;
                  bus.led       <= '0;
                  bus.led_valid <= 1'b1;
               end else begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mux_row_scheduler.sv
// Directed bench for mux_row_scheduler with ROW_CYCLES=64, BLANK_CYCLES=8.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_mux_row_scheduler;
   localparam int NB_LEDS = 16;
   localparam int NB_ROWS = 4;
   localparam int ROW_CYC = 64;
   localparam int BLK_CYC = 8;

   logic clk = 1'b0;
   logic rst;
   logic enable;
   logic busy;
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;

   mux_row_scheduler_if #(.NB_LEDS_PER_GROUP(NB_LEDS), .NB_MUX_ROWS(NB_ROWS)) bus ();

   mux_row_scheduler #(
      .NB_LEDS_PER_GROUP (NB_LEDS),
      .NB_MUX_ROWS       (NB_ROWS),
      .ROW_CYCLES        (ROW_CYC),
      .BLANK_CYCLES      (BLK_CYC)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .enable (enable),
      .busy   (busy),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset(input string p);
      check({p, " mux_en"},      32'(bus.mux_en), 32'h0);
      check({p, " blank"},       32'(bus.blank), 32'h1);
      check({p, " led"},         32'(bus.led), 32'h0);
      check({p, " led_valid"},   32'(bus.led_valid), 32'h0);
      check({p, " latch"},       32'(bus.latch), 32'h0);
      check({p, " frame_start"}, 32'(bus.frame_start), 32'h0);
      check({p, " busy"},        32'(busy), 32'h0);
   endtask

   initial begin
      logic [3:0] seq [6];
      logic [3:0] cur;
      int n;
      int d;
      int l;
      int e;
      int t_on;
      logic rdy;

      seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100;
      seq[3] = 4'b1000; seq[4] = 4'b0001; seq[5] = 4'b0010;

      rst = 1'b1; enable = 1'b0; bus.led_ready = 1'b0; bus.drv_done = 1'b0;
      step(); step();
      check_reset("reset");

      // Startup: first row needs no timer, only the driver completion.
      rst = 1'b0; enable = 1'b1; bus.led_ready = 1'b1;
      step();
      check("start busy", 32'(busy), 32'h1);
      for (int i = 0; i < NB_LEDS; i++) begin
         check("start led", 32'(bus.led), 32'(i));
         check("start led_valid", 32'(bus.led_valid), 32'h1);
         step();
      end
      check("shift end valid", 32'(bus.led_valid), 32'h0);
      check("shift end led", 32'(bus.led), 32'h0);
      step(); step();
      bus.drv_done = 1'b1;
      step();
      bus.drv_done = 1'b0;
      for (int i = 0; i < BLK_CYC; i++) begin
         check("blank held", 32'(bus.blank), 32'h1);
         check("blank no latch", 32'(bus.latch), 32'h0);
         check("blank mux_en", 32'(bus.mux_en), 32'h0);
         step();
      end
      check("latch pulse", 32'(bus.latch), 32'h1);
      check("latch mux_en", 32'(bus.mux_en), 32'h0);
      step();
      check("row0 mux_en", 32'(bus.mux_en), 32'h1);
      check("row0 frame_start", 32'(bus.frame_start), 32'h1);
      check("row0 latch low", 32'(bus.latch), 32'h0);
      check("row0 blank low", 32'(bus.blank), 32'h0);

      // Rotation: drv_done during the first SHIFT cycle, so only the row timer gates the switch.
      for (int r = 0; r < 5; r++) begin
         cur = seq[r];
         bus.drv_done = 1'b1;
         step();
         bus.drv_done = 1'b0;
         n = 1;
         while (bus.mux_en === cur && n < 300) begin
            n++;
            step();
         end
         check("rot on cycles", 32'(n), 32'(ROW_CYC));
         d = 0; l = 0;
         while (bus.mux_en === 4'b0000 && d < 50) begin
            if (bus.latch === 1'b1) l++;
            d++;
            step();
         end
         check("rot dark cycles", 32'(d), 32'(BLK_CYC + 1));
         check("rot latch count", 32'(l), 32'h1);
         check("rot mux_en", 32'(bus.mux_en), 32'(seq[r+1]));
         check("rot frame_start", 32'(bus.frame_start), (seq[r+1] == 4'b0001) ? 32'h1 : 32'h0);
      end
      t_on = cyc;

      // Backpressure with ready pattern 1,0,0 repeating.
      e = 0;
      for (int c = 0; c < 100 && bus.led_valid === 1'b1; c++) begin
         check("bp led", 32'(bus.led), 32'(e));
         rdy = (c % 3 == 0);
         bus.led_ready = rdy;
         step();
         if (rdy) e++;
      end
      bus.led_ready = 1'b1;
      check("bp count", 32'(e), 32'(NB_LEDS));
      check("bp valid low", 32'(bus.led_valid), 32'h0);

      // Late driver: done arrives 200 cycles after the row timer expired at t_on+63.
      while (cyc < t_on + ROW_CYC - 1 + 200) step();
      check("late still on", 32'(bus.mux_en), 32'b0010);
      bus.drv_done = 1'b1;
      step();
      bus.drv_done = 1'b0;
      check("late off", 32'(bus.mux_en), 32'h0);

      // Disable during WAIT of row 2: row 3 latches and is held its full time.
      for (int c = 0; c < 20 && bus.mux_en === 4'b0000; c++) step();
      check("dis row2", 32'(bus.mux_en), 32'b0100);
      for (int c = 0; c < 40 && bus.led_valid === 1'b1; c++) step();
      enable = 1'b0;
      bus.drv_done = 1'b1;
      step();
      bus.drv_done = 1'b0;
      for (int c = 0; c < 100 && bus.mux_en !== 4'b1000; c++) step();
      check("dis row3", 32'(bus.mux_en), 32'b1000);
      check("dis busy low", 32'(busy), 32'h0);
      check("dis frame_start", 32'(bus.frame_start), 32'h0);
      n = 1;
      step();
      while (bus.mux_en === 4'b1000 && n < 300) begin
         n++;
         step();
      end
      check("dis hold cycles", 32'(n), 32'(ROW_CYC));
      check("dis off mux_en", 32'(bus.mux_en), 32'h0);
      check("dis off blank", 32'(bus.blank), 32'h1);
      check("dis off busy", 32'(busy), 32'h0);
      for (int c = 0; c < 5; c++) step();
      check("idle no valid", 32'(bus.led_valid), 32'h0);
      check("idle dark", 32'(bus.mux_en), 32'h0);

      enable = 1'b1;
      step();
      check("reen valid", 32'(bus.led_valid), 32'h1);
      check("reen led", 32'(bus.led), 32'h0);
      check("reen busy", 32'(busy), 32'h1);
      bus.drv_done = 1'b1;
      step();
      bus.drv_done = 1'b0;
      for (int c = 0; c < 40 && bus.mux_en === 4'b0000; c++) step();
      check("reen mux_en", 32'(bus.mux_en), 32'b0001);
      check("reen frame_start", 32'(bus.frame_start), 32'h1);

      // Mid-row reset at led=7.
      for (int c = 0; c < 30 && bus.led !== 4'd7; c++) step();
      check("mid led7", 32'(bus.led), 32'h7);
      rst = 1'b1;
      step();
      check_reset("midrst");
      rst = 1'b0;
      step();
      check("restart valid", 32'(bus.led_valid), 32'h1);
      check("restart led", 32'(bus.led), 32'h0);
      check("restart mux_en", 32'(bus.mux_en), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/mux_row_scheduler.md
# mux_row_scheduler

Sequences LED multiplexing for one driver group. It walks the 16 driver outputs so that next-row data can be fetched and shifted into the LED drivers, and enforces a minimum display time per multiplexing row. Between rows it inserts a blanking interval, pulses the driver latch, then advances the one-hot multiplexing enable. It sits between the frame-buffer read path and the LED driver shift/latch logic, and owns the `mux_en` bus consumed by the row lookup table.

## Interface
- `NB_LEDS_PER_GROUP`, 16: driver outputs per group; `led` width is `$clog2` of this.
- `NB_MUX_ROWS`, 4: multiplexing rows; `mux_en` width.
- `ROW_CYCLES`, 4096: minimum clk cycles a row stays enabled, counted from its switch-on; ≥ 1.
- `BLANK_CYCLES`, 8: cycles with all rows off before each latch; ≥ 1.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `enable`, in, 1: run request; level-sensitive.
- `led`, out, `$clog2(NB_LEDS_PER_GROUP)`: driver output index being requested.
- `led_valid`, out, 1: `led` is valid.
- `led_ready`, in, 1: downstream accepts `led` in this cycle.
- `drv_done`, in, 1: one-cycle pulse; the driver finished shifting all outputs for the pending row.
- `latch`, out, 1: one-cycle driver latch pulse.
- `blank`, out, 1: high whenever `mux_en` is all zeros.
- `mux_en`, out, `NB_MUX_ROWS`: one-hot active row, or zero.
- `frame_start`, out, 1: one-cycle pulse when row 0 switches on.
- `busy`, out, 1: high in every state except IDLE.

## Operation
- States: IDLE, SHIFT, WAIT, BLANK, LATCH.
- **Reset** (any state, mid-row included) → IDLE. Reset values: `mux_en`=0, `blank`=1, `led`=0, `led_valid`=0, `latch`=0, `frame_start`=0, `busy`=0. The row timer, blank counter and `done_seen` all clear.
- **IDLE**
  - `mux_en`=0, so the lookup table targets row 0.
  - `enable`=1 → SHIFT, `led`=0.
- **SHIFT**
  - `led_valid`=1.
  - On `led_valid && led_ready`, `led` increments.
  - Acceptance at `led`=`NB_LEDS_PER_GROUP-1` → WAIT, with `led_valid`=0 and `led` back to 0.
  - `led` must not change while valid and not ready.
  - Next-row data always corresponds to the row following the current `mux_en`; this relies on the lookup table's "next row" semantics.
- **WAIT**
  - `drv_done` sets sticky `done_seen`. `drv_done` arriving during SHIFT is also captured.
  - Exit → BLANK when `done_seen` and the row timer has expired.
  - If `mux_en`=0 (first row after IDLE), the timer counts as expired.
- **BLANK**
  - `mux_en`=0, `blank`=1 for exactly `BLANK_CYCLES` cycles, then → LATCH.
- **LATCH**
  - `latch`=1 for one cycle; `done_seen` clears.
  - Next cycle: `mux_en` = one-hot(next row). Next row is (current+1) mod `NB_MUX_ROWS`; from zero it is row 0.
  - If the new row is 0, `frame_start` pulses in that same cycle.
  - The row timer restarts at that same cycle.
  - Then `enable`=1 → SHIFT; `enable`=0 → IDLE.
- **Disable path**
  - On the IDLE exit, `mux_en` stays on the newly latched row until the row timer expires.
  - Then `mux_en`=0 and `blank`=1.
  - `enable` is sampled only at these boundaries.
  - Re-enable restarts at row 0 data.
- **Row index arithmetic**
  - Held internally as a `$clog2(NB_MUX_ROWS)`-bit counter with explicit wrap.
  - `mux_en` is decoded from it, so it is never multi-hot.
- **Row timer**: saturates at `ROW_CYCLES`; width `$clog2(ROW_CYCLES+1)`.

## Timing
- All outputs are registered; no combinational input→output path.
- IDLE→SHIFT: `led_valid` rises one cycle after `enable` is seen high.
- With `led_ready` tied high, SHIFT lasts exactly `NB_LEDS_PER_GROUP` cycles.
- Row switch sequence: last WAIT cycle → `BLANK_CYCLES` cycles with `mux_en`=0 → one `latch` cycle (`mux_en` still 0) → new `mux_en`.
- Total dark time per switch is `BLANK_CYCLES`+1 cycles.
- `drv_done` and the timer expiring in the same cycle → BLANK on the next cycle.
- `drv_done` while in BLANK or LATCH is ignored.

## Structure
- Package `mux_sched_pkg` holds:
  - the state enum `mux_sched_state_t`;
  - `NB_MUX_ROWS_DEFAULT`;
  - function `row_onehot(idx)`.
- One sub-module, `mux_row_timer`: loadable saturating up-counter with an `expired` flag. The row timer and the blank counter both instantiate it.
- FSM, `led` counter and row counter live in the top module.

## Test plan
- **Startup:** reset, `enable`=1, `led_ready`=1, `drv_done` 3 cycles after SHIFT ends.
  - Expect `led` 0..15 over 16 cycles.
  - Expect `blank` held for 8 cycles, then `latch` pulse.
  - Expect `mux_en`=0001 with `frame_start`=1 in the same cycle.
- **Rotation:** `ROW_CYCLES`=64 over 5 row switches.
  - Expect `mux_en` 0001→0010→0100→1000→0001.
  - Each row on ≥64 cycles; `frame_start` only on the 0001 cycles.
- **Backpressure:** `led_ready` toggles 1,0,0,1…
  - `led` is held stable while not ready; all 16 indices appear once, in order.
- **Late driver:** `drv_done` 200 cycles after the timer expires.
  - `mux_en` stays on the current row until 201 cycles past expiry.
- **Disable:** drop `enable` during WAIT of row 2.
  - Row 3 latches, stays on `ROW_CYCLES`, then `mux_en`=0, `busy`=0.
  - Re-enable → `mux_en` returns to 0001.
- **Mid-row reset:** assert `rst` during SHIFT at `led`=7.
  - All outputs are at reset values next cycle.
  - Restart produces `led`=0 first.
